// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART.
`timescale 1ns/1ps
package uart_pkg;

  // Smallest usable bit period; shorter divisors are clamped up to this.
  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Parity bit that makes XOR(data, bit) equal to odd.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
`timescale 1ns/1ps
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

  // A pop on an empty FIFO is ignored; a push on a full FIFO only lands
  // when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head of the FIFO is presented combinationally; zero when empty.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // Pointer and count update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_trx.sv
// Full-duplex UART with TX/RX FIFOs, programmable divisor, parity and stop bits.
`timescale 1ns/1ps
module uart_fifo_trx
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [DIV_W-1:0]         i_div,
  input  logic                     i_par_en,
  input  logic                     i_par_odd,
  input  logic                     i_stop2,
  input  logic                     i_tx_wr,
  input  logic [7:0]               i_tx_data,
  output logic                     o_tx_full,
  output logic                     o_tx_empty,
  output logic                     o_tx_busy,
  input  logic                     i_rx_rd,
  output logic [7:0]               o_rx_data,
  output logic                     o_rx_empty,
  output logic                     o_rx_full,
  output logic [$clog2(DEPTH):0]   o_rx_level,
  input  logic                     i_err_clr,
  output logic                     o_frame_err,
  output logic                     o_parity_err,
  output logic                     o_overrun,
  output logic                     o_irq_rx,
  output logic                     o_irq_tx,
  input  logic                     i_RX,
  output logic                     o_TX
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (i_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div;

  // ---------------- FIFOs ----------------
  logic [7:0]    tx_head;
  logic          tx_full, tx_empty, tx_pop;
  logic [LW-1:0] tx_level;
  logic          rx_push, rx_full, rx_empty;
  logic [7:0]    rx_shift_q, rx_shift_d;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .clr   (!i_en),
    .push  (i_tx_wr && !tx_full),
    .pop   (tx_pop),
    .wdata (i_tx_data),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .clr   (!i_en),
    .push  (rx_push),
    .pop   (i_rx_rd),
    .wdata (rx_shift_q),
    .rdata (o_rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (o_rx_level)
  );

  assign o_tx_full  = tx_full;
  assign o_tx_empty = tx_empty;
  assign o_rx_full  = rx_full;
  assign o_rx_empty = rx_empty;

  // ---------------- TX ----------------
  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d;
  logic             tx_par_q, tx_par_d, tx_stop_idx_q, tx_stop_idx_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_bit_end, tx_start_frame;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 1'b1);
  assign o_TX       = tx_line_q;
  assign o_tx_busy  = (tx_state_q != TX_IDLE);

  // TX next state: a new frame starts from IDLE or directly after the last
  // stop bit so queued bytes go out without an idle gap.
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_div_d       = tx_div_q;
    tx_bit_d       = tx_bit_q;
    tx_shift_d     = tx_shift_q;
    tx_par_en_d    = tx_par_en_q;
    tx_stop2_d     = tx_stop2_q;
    tx_par_d       = tx_par_q;
    tx_stop_idx_d  = tx_stop_idx_q;
    tx_line_d      = tx_line_q;
    tx_pop         = 1'b0;
    tx_start_frame = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (!tx_empty) tx_start_frame = 1'b1;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
            tx_stop_idx_d = 1'b0;
            if (tx_par_en_q) begin
              tx_state_d = TX_PARITY;
              tx_line_d  = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2_q && !tx_stop_idx_q) begin
            tx_stop_idx_d = 1'b1;
          end else if (!tx_empty) begin
            tx_start_frame = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_start_frame) begin
      tx_state_d    = TX_START;
      tx_cnt_d      = '0;
      tx_line_d     = 1'b0;
      tx_shift_d    = tx_head;
      tx_div_d      = div_eff;
      tx_par_en_d   = i_par_en;
      tx_stop2_d    = i_stop2;
      tx_par_d      = parity_bit(tx_head, i_par_odd);
      tx_stop_idx_d = 1'b0;
      tx_pop        = 1'b1;
    end
    if (!i_en) begin
      tx_state_d    = TX_IDLE;
      tx_cnt_d      = '0;
      tx_div_d      = DIV_W'(MIN_DIV);
      tx_bit_d      = '0;
      tx_shift_d    = '0;
      tx_par_en_d   = 1'b0;
      tx_stop2_d    = 1'b0;
      tx_par_d      = 1'b0;
      tx_stop_idx_d = 1'b0;
      tx_line_d     = 1'b1;
      tx_pop        = 1'b0;
    end
  end

  // TX state registers; the line returns high the instant reset asserts.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_div_q      <= DIV_W'(MIN_DIV);
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_en_q   <= 1'b0;
      tx_stop2_q    <= 1'b0;
      tx_par_q      <= 1'b0;
      tx_stop_idx_q <= 1'b0;
      tx_line_q     <= 1'b1;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_div_q      <= tx_div_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_en_q   <= tx_par_en_d;
      tx_stop2_q    <= tx_stop2_d;
      tx_par_q      <= tx_par_d;
      tx_stop_idx_q <= tx_stop_idx_d;
      tx_line_q     <= tx_line_d;
    end
  end

  // ---------------- RX ----------------
  logic rx_s1_q, rx_s2_q;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else if (!i_en) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= i_RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic             rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic             rx_half_end, rx_bit_end;
  logic             frame_evt, parity_evt, overrun_evt;

  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 1'b1);
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 1'b1);

  // RX next state: start bit is re-checked at half a bit, the rest sampled
  // one bit period apart; a low stop bit parks in WAIT_HIGH until the line
  // recovers so a held break yields a single byte.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 1'b1;
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_push      = 1'b0;
    frame_evt    = 1'b0;
    parity_evt   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) begin
          rx_state_d   = RX_START;
          rx_div_d     = div_eff;
          rx_par_en_d  = i_par_en;
          rx_par_odd_d = i_par_odd;
        end
      end
      RX_START: begin
        if (rx_half_end) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          parity_evt = (rx_s2_q != parity_bit(rx_shift_q, rx_par_odd_q));
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_push  = 1'b1;
          if (!rx_s2_q) begin
            frame_evt  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!i_en) begin
      rx_state_d   = RX_IDLE;
      rx_cnt_d     = '0;
      rx_div_d     = DIV_W'(MIN_DIV);
      rx_bit_d     = '0;
      rx_shift_d   = '0;
      rx_par_en_d  = 1'b0;
      rx_par_odd_d = 1'b0;
      rx_push      = 1'b0;
      frame_evt    = 1'b0;
      parity_evt   = 1'b0;
    end
  end

  // RX state registers; reset discards any partially received byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= DIV_W'(MIN_DIV);
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
    end
  end

  // ---------------- Flags and interrupts ----------------
  logic frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic overrun_q, overrun_d, irq_rx_q, irq_rx_d, irq_tx_q, irq_tx_d;

  // A pop in the same cycle makes room, so that push is not an overrun.
  assign overrun_evt = rx_push && rx_full && !i_rx_rd;

  // Sticky flags: a new event wins over a simultaneous clear.
  always_comb begin
    frame_err_d  = (frame_err_q  && !i_err_clr) || frame_evt;
    parity_err_d = (parity_err_q && !i_err_clr) || parity_evt;
    overrun_d    = (overrun_q    && !i_err_clr) || overrun_evt;
    irq_rx_d     = !rx_empty;
    irq_tx_d     = (tx_level == '0) && (tx_state_q == TX_IDLE);
    if (!i_en) begin
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      irq_rx_d     = 1'b0;
      irq_tx_d     = 1'b0;
    end
  end

  // Flag and interrupt registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      irq_rx_q     <= 1'b0;
      irq_tx_q     <= 1'b0;
    end else begin
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      irq_rx_q     <= irq_rx_d;
      irq_tx_q     <= irq_tx_d;
    end
  end

  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = overrun_q;
  assign o_irq_rx     = irq_rx_q;
  assign o_irq_tx     = irq_tx_q;

endmodule

// File: tb/tb_uart_fifo_trx.sv
// Scoreboard bench for uart_fifo_trx: RX bytes checked by a monitor process.
`timescale 1ns/1ps
module tb_uart_fifo_trx;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             i_rst, i_en;
  logic [DIV_W-1:0] i_div;
  logic             i_par_en, i_par_odd, i_stop2;
  logic             i_tx_wr;
  logic [7:0]       i_tx_data;
  logic             o_tx_full, o_tx_empty, o_tx_busy;
  logic             i_rx_rd;
  logic [7:0]       o_rx_data;
  logic             o_rx_empty, o_rx_full;
  logic [4:0]       o_rx_level;
  logic             i_err_clr;
  logic             o_frame_err, o_parity_err, o_overrun, o_irq_rx, o_irq_tx;
  logic             rx_line, o_TX;
  logic             rx_drv, loop_en, mon_en;

  assign rx_line = loop_en ? o_TX : rx_drv;

  uart_fifo_trx #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_div(i_div),
    .i_par_en(i_par_en), .i_par_odd(i_par_odd), .i_stop2(i_stop2),
    .i_tx_wr(i_tx_wr), .i_tx_data(i_tx_data),
    .o_tx_full(o_tx_full), .o_tx_empty(o_tx_empty), .o_tx_busy(o_tx_busy),
    .i_rx_rd(i_rx_rd), .o_rx_data(o_rx_data), .o_rx_empty(o_rx_empty),
    .o_rx_full(o_rx_full), .o_rx_level(o_rx_level), .i_err_clr(i_err_clr),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err), .o_overrun(o_overrun),
    .o_irq_rx(o_irq_rx), .o_irq_tx(o_irq_tx), .i_RX(rx_line), .o_TX(o_TX)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops every byte the RX FIFO presents and compares it with the queue.
  initial begin
    i_rx_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (i_rx_rd) begin
        i_rx_rd = 1'b0;
      end else if (mon_en && !o_rx_empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%02h expected no byte", o_rx_data);
        end else begin
          chk("rx_byte", 32'(o_rx_data), 32'(exp_q.pop_front()));
          $display("rx byte 0x%02h", o_rx_data);
        end
        i_rx_rd = 1'b1;
      end
    end
  end

  // Counts cycles with the TX FSM out of IDLE.
  always @(negedge clk) if (o_tx_busy) busy_cnt++;

  // Hard stop if something hangs.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    i_tx_data = d;
    i_tx_wr   = 1'b1;
    @(negedge clk);
    i_tx_wr   = 1'b0;
  endtask

  // Drives one serial frame on the bench-side RX line; leaves line at stop value.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic odd,
                            input logic stop_val, input int div);
    rx_drv = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(div);
    end
    if (pe) begin
      rx_drv = (^d) ^ odd;
      tick(div);
    end
    rx_drv = stop_val;
    tick(div);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    tick(3);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (o_tx_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(o_tx_busy), 32'd0);
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    i_rst = 1'b0; i_en = 1'b1; i_div = 16'd16;
    i_par_en = 1'b0; i_par_odd = 1'b0; i_stop2 = 1'b0;
    i_tx_wr = 1'b0; i_tx_data = 8'h00; i_err_clr = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0; mon_en = 1'b0;
    tick(3);

    // Reset values
    chk("rst_tx_line", 32'(o_TX), 32'd1);
    chk("rst_empties", 32'({o_tx_empty, o_rx_empty}), 32'b11);
    chk("rst_flags", 32'({o_tx_full, o_rx_full, o_frame_err, o_parity_err, o_overrun,
                          o_irq_rx, o_irq_tx, o_tx_busy}), 32'd0);
    chk("rst_level", 32'(o_rx_level), 32'd0);
    chk("rst_rx_data", 32'(o_rx_data), 32'd0);
    i_rst = 1'b1;
    tick(3);
    chk("irq_tx_idle", 32'(o_irq_tx), 32'd1);

    // 8N1 0x55 at div 16: start, 1,0,1,0,1,0,1,0, stop -> level k%2, 16 cycles each
    busy_cnt = 0;
    write_tx(8'h55);
    chk("tx_latency_pre", 32'(o_TX), 32'd1);
    for (int k = 0; k < 10; k++) begin
      int bad = 0;
      repeat (16) begin
        @(negedge clk);
        if (o_TX !== 1'(k % 2)) bad++;
      end
      chk($sformatf("tx55_bit%0d", k), 32'(bad), 32'd0);
    end
    tick(2);
    chk("tx55_irq_tx", 32'(o_irq_tx), 32'd1);
    chk("tx55_busy_cycles", 32'(busy_cnt), 32'd160);

    // Loopback, even parity, 2 stop bits: frames of 12*16 = 192 cycles
    i_par_en = 1'b1; i_par_odd = 1'b0; i_stop2 = 1'b1;
    loop_en = 1'b1; mon_en = 1'b1;
    tick(2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    busy_cnt = 0;
    write_tx(8'hA3); write_tx(8'h00); write_tx(8'hFF);
    wait_idle("lb_tx_idle", 2000);
    chk("lb_busy_cycles", 32'(busy_cnt), 32'd576);
    wait_drain("lb_rx_drained", 500);
    chk("lb_no_errors", 32'({o_frame_err, o_parity_err, o_overrun}), 32'd0);

    // TX FIFO fill: FSM busy with a primer byte, then 17 writes; last one dropped
    i_par_en = 1'b0; i_stop2 = 1'b0; i_div = 16'd8;
    tick(2);
    busy_cnt = 0;
    exp_q.push_back(8'h11);
    write_tx(8'h11);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h20 + i));
      write_tx(8'(8'h20 + i));
    end
    chk("fill_tx_full", 32'(o_tx_full), 32'd1);
    wait_idle("fill_tx_idle", 3000);
    chk("fill_busy_cycles", 32'(busy_cnt), 32'd1360);
    wait_drain("fill_rx_drained", 500);
    tick(100);
    chk("fill_no_extra", 32'(o_rx_level), 32'd0);

    // RX overrun: 17 frames with no reads
    loop_en = 1'b0; mon_en = 1'b0; rx_drv = 1'b1;
    tick(4);
    for (int i = 0; i < 17; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b1, 8);
    tick(16);
    chk("ovr_level", 32'(o_rx_level), 32'd16);
    chk("ovr_full", 32'(o_rx_full), 32'd1);
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    chk("ovr_head", 32'(o_rx_data), 32'h40);
    chk("ovr_irq_rx", 32'(o_irq_rx), 32'd1);
    pulse_clr();
    chk("ovr_cleared", 32'(o_overrun), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    mon_en = 1'b1;
    wait_drain("ovr_drained", 200);
    chk("ovr_empty", 32'(o_rx_empty), 32'd1);

    // Parity error: DUT expects even, bench sends odd
    i_par_en = 1'b1; i_par_odd = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 8);
    tick(8);
    chk("par_err", 32'({o_parity_err, o_frame_err}), 32'b10);
    wait_drain("par_drained", 100);
    pulse_clr();
    chk("par_cleared", 32'(o_parity_err), 32'd0);
    i_par_en = 1'b0;

    // Frame error with line held low (break)
    mon_en = 1'b0;
    tick(4);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8);
    tick(24);
    chk("brk_frame_err", 32'(o_frame_err), 32'd1);
    chk("brk_level_low", 32'(o_rx_level), 32'd1);
    rx_drv = 1'b1;
    tick(40);
    chk("brk_level_after", 32'(o_rx_level), 32'd1);
    exp_q.push_back(8'h3C);
    mon_en = 1'b1;
    wait_drain("brk_drained", 100);
    pulse_clr();

    // 8-cycle glitch at div 32: no byte; a real frame afterwards still decodes
    i_div = 16'd32;
    tick(4);
    rx_drv = 1'b0;
    tick(8);
    rx_drv = 1'b1;
    tick(100);
    chk("glitch_no_push", 32'(o_rx_level), 32'd0);
    exp_q.push_back(8'h9A);
    send_frame(8'h9A, 1'b0, 1'b0, 1'b1, 32);
    wait_drain("glitch_then_frame", 200);
    chk("glitch_no_errors", 32'({o_frame_err, o_parity_err}), 32'd0);

    // Async reset mid-frame
    i_div = 16'd16; loop_en = 1'b1; mon_en = 1'b0;
    tick(4);
    write_tx(8'h00);
    write_tx(8'h5A);
    tick(40);
    chk("mid_tx_low", 32'(o_TX), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("mid_rst_tx_high", 32'(o_TX), 32'd1);
    @(negedge clk);
    i_rst = 1'b1;
    tick(2);
    chk("mid_fifos_empty", 32'({o_tx_empty, o_rx_empty}), 32'b11);
    chk("mid_busy", 32'(o_tx_busy), 32'd0);
    tick(300);
    chk("mid_rx_discard", 32'(o_rx_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
